// File: rtl/i2c_sensor_target.sv
// I2C target emulating an on-board sensor: oversampled SCL/SDA, START/STOP decode,
// register pointer write, forwarded write bytes and 16-bit MSB-first register reads.
module i2c_sensor_target #(
  parameter logic [6:0]  DEV_ADDR  = 7'h48,
  parameter int unsigned PTR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 scl_i,
  input  logic                 sda_i,
  output logic                 sda_oe_o,
  output logic [PTR_WIDTH-1:0] reg_ptr_o,
  input  logic [15:0]          reg_rdata_i,
  output logic [7:0]           wr_data_o,
  output logic                 wr_valid_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           snap_lo_q, snap_lo_d;
  logic                 rw_q, rw_d;
  logic                 byte_sel_q, byte_sel_d;
  logic                 sda_oe_q, sda_oe_d;
  logic [PTR_WIDTH-1:0] reg_ptr_q, reg_ptr_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic                 wr_valid_q, wr_valid_d;
  logic                 busy_q, busy_d;

  logic scl_s1_q, scl_s2_q, scl_d_q;
  logic sda_s1_q, sda_s2_q, sda_d_q;

  logic       scl_rise, scl_fall, start_det, stop_det, load_rd;
  logic [7:0] byte_in;

  // Two-flop synchronizers plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_d_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_d_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl_i;
      scl_s2_q <= scl_s1_q;
      scl_d_q  <= scl_s2_q;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
      sda_d_q  <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_d_q;
  assign scl_fall  = ~scl_s2_q & scl_d_q;
  assign start_det = scl_s2_q & scl_d_q & sda_d_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_d_q & ~sda_d_q & sda_s2_q;
  assign byte_in   = {shift_q[6:0], sda_s2_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      snap_lo_q  <= '0;
      rw_q       <= 1'b0;
      byte_sel_q <= 1'b0;
      sda_oe_q   <= 1'b0;
      reg_ptr_q  <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      snap_lo_q  <= snap_lo_d;
      rw_q       <= rw_d;
      byte_sel_q <= byte_sel_d;
      sda_oe_q   <= sda_oe_d;
      reg_ptr_q  <= reg_ptr_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    snap_lo_d  = snap_lo_q;
    rw_d       = rw_q;
    byte_sel_d = byte_sel_q;
    sda_oe_d   = sda_oe_q;
    reg_ptr_d  = reg_ptr_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = 1'b0;
    busy_d     = busy_q;
    load_rd    = 1'b0;

    // Bus conditions take precedence over any SCL edge in the same cycle
    if (start_det) begin
      state_d    = S_ADDR;
      bit_cnt_d  = '0;
      sda_oe_d   = 1'b0;
      byte_sel_d = 1'b0;
      busy_d     = 1'b0;
    end else if (stop_det) begin
      state_d    = S_IDLE;
      sda_oe_d   = 1'b0;
      byte_sel_d = 1'b0;
      busy_d     = 1'b0;
    end else begin
      unique case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else if (scl_fall && bit_cnt_q == CNT_W'(8)) begin
            if (shift_q[7:1] == DEV_ADDR) begin
              state_d  = S_ADDR_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              rw_d     = shift_q[0];
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              state_d = S_RD_DATA;
              load_rd = 1'b1;
            end else begin
              state_d  = S_PTR;
              sda_oe_d = 1'b0;
            end
          end
        end
        S_PTR, S_WR_DATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              if (state_q == S_PTR) begin
                reg_ptr_d = PTR_WIDTH'(byte_in);
              end else begin
                wr_data_d  = byte_in;
                wr_valid_d = 1'b1;
              end
            end
          end else if (scl_fall && bit_cnt_q == CNT_W'(8)) begin
            state_d  = S_WR_ACK;
            sda_oe_d = 1'b1;
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            state_d   = S_WR_DATA;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
          end
        end
        S_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else if (scl_fall) begin
            if (bit_cnt_q == CNT_W'(8)) begin
              state_d  = S_RD_ACK;
              sda_oe_d = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        S_RD_ACK: begin
          // bit_cnt==9 marks that the controller acknowledged this byte
          if (scl_rise) begin
            bit_cnt_d = CNT_W'(9);
            if (byte_sel_q) reg_ptr_d = reg_ptr_q + PTR_WIDTH'(1);
            if (sda_s2_q) begin
              state_d    = S_IGNORE;
              byte_sel_d = 1'b0;
              busy_d     = 1'b0;
            end else begin
              byte_sel_d = ~byte_sel_q;
            end
          end else if (scl_fall && bit_cnt_q == CNT_W'(9)) begin
            state_d = S_RD_DATA;
            load_rd = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Read byte load: MSB half snapshots the register, LSB half replays the snapshot
    if (load_rd) begin
      bit_cnt_d = '0;
      if (!byte_sel_q) begin
        snap_lo_d = reg_rdata_i[7:0];
        shift_d   = reg_rdata_i[15:8];
        sda_oe_d  = ~reg_rdata_i[15];
      end else begin
        shift_d  = snap_lo_q;
        sda_oe_d = ~snap_lo_q[7];
      end
    end
  end

  assign sda_oe_o   = sda_oe_q;
  assign reg_ptr_o  = reg_ptr_q;
  assign wr_data_o  = wr_data_q;
  assign wr_valid_o = wr_valid_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_sensor_target.sv
// Bench for i2c_sensor_target: bit-banged I2C controller with open-drain SDA model
// and scoreboard queues for read bytes and forwarded write bytes.
module tb_i2c_sensor_target;

  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl_m, sda_m;
  logic        scl_i, sda_i;
  logic        sda_oe_o;
  logic [7:0]  reg_ptr_o;
  logic [15:0] reg_rdata_i;
  logic [7:0]  wr_data_o;
  logic        wr_valid_o;
  logic        busy_o;

  logic [15:0] regs [256];
  logic [7:0]  exp_rd [$];
  logic [7:0]  exp_wr [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          oe_cnt = 0;
  int          wr_cnt = 0;
  logic [7:0]  exp_ptr;

  always #5 clk = ~clk;

  assign scl_i       = scl_m;
  assign sda_i       = sda_m & ~sda_oe_o;
  assign reg_rdata_i = regs[reg_ptr_o];

  i2c_sensor_target #(.DEV_ADDR(7'h48), .PTR_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_oe_o   (sda_oe_o),
    .reg_ptr_o  (reg_ptr_o),
    .reg_rdata_i(reg_rdata_i),
    .wr_data_o  (wr_data_o),
    .wr_valid_o (wr_valid_o),
    .busy_o     (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sda_oe_o) oe_cnt <= oe_cnt + 1;
    if (rst_n && wr_valid_o) begin
      wr_cnt <= wr_cnt + 1;
      if (exp_wr.size() == 0) check("wr_unexpected", 32'(wr_data_o), 32'hFFFF_FFFF);
      else check("wr_data", 32'(wr_data_o), 32'(exp_wr.pop_front()));
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; clks(H);
    scl_m = 1'b1; clks(H);
    sda_m = 1'b0; clks(H);
    scl_m = 1'b0; clks(2);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; clks(H - 2);
    scl_m = 1'b1; clks(H);
    sda_m = 1'b1; clks(H);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; clks(H - 2);
    scl_m = 1'b1; clks(H);
    scl_m = 1'b0; clks(2);
  endtask

  task automatic sample_bit(output logic b);
    sda_m = 1'b1; clks(H - 2);
    scl_m = 1'b1; clks(H / 2);
    @(negedge clk) b = sda_i;
    clks(H / 2);
    scl_m = 1'b0; clks(2);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    sample_bit(ack);
  endtask

  task automatic read_byte(input logic ack_in);
    logic [7:0] b;
    for (int i = 7; i >= 0; i--) sample_bit(b[i]);
    write_bit(ack_in);
    if (exp_rd.size() == 0) check("rd_underflow", 32'(b), 32'hFFFF_FFFF);
    else check("rd_byte", 32'(b), 32'(exp_rd.pop_front()));
  endtask

  task automatic push_word(input logic [7:0] ptr);
    logic [15:0] w;
    w = regs[ptr];
    exp_rd.push_back(w[15:8]);
    exp_rd.push_back(w[7:0]);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  initial begin
    logic ack;
    int   oe_before, wr_before;
    bit   seen;

    for (int i = 0; i < 256; i++) regs[i] = 16'(i * 257);
    regs[0] = 16'h3C5A;
    regs[5] = 16'h1A2B;
    regs[7] = 16'hBEEF;
    regs[8] = 16'h0000;

    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    clks(3);
    @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe_o), 32'd0);
    check("rst_ptr", 32'(reg_ptr_o), 32'd0);
    check("rst_wr_data", 32'(wr_data_o), 32'd0);
    check("rst_wr_valid", 32'(wr_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1;
    clks(4);

    // 1: pointer write only
    wr_before = wr_cnt;
    i2c_start();
    send_byte(8'h90, ack); check("t1_addr_ack", 32'(ack), 32'd0);
    check("t1_busy", 32'(busy_o), 32'd1);
    send_byte(8'h05, ack); check("t1_ptr_ack", 32'(ack), 32'd0);
    i2c_stop();
    exp_ptr = 8'h05;
    check("t1_ptr", 32'(reg_ptr_o), 32'(exp_ptr));
    check("t1_no_wr", 32'(wr_cnt), 32'(wr_before));
    check("t1_busy_end", 32'(busy_o), 32'd0);

    // 2: two-byte read, ACK then NACK
    push_word(exp_ptr);
    i2c_start();
    send_byte(8'h91, ack); check("t2_addr_ack", 32'(ack), 32'd0);
    read_byte(1'b0);
    read_byte(1'b1);
    i2c_stop();
    exp_ptr = exp_ptr + 8'd1;
    check("t2_ptr", 32'(reg_ptr_o), 32'(exp_ptr));

    // 3: foreign address is never acknowledged
    oe_before = oe_cnt;
    i2c_start();
    send_byte(8'h80, ack); check("t3_nack", 32'(ack), 32'd1);
    check("t3_oe_quiet", 32'(oe_cnt - oe_before), 32'd0);
    check("t3_busy", 32'(busy_o), 32'd0);
    i2c_stop();

    // 4: pointer plus two data bytes
    exp_wr.push_back(8'hAA);
    exp_wr.push_back(8'h55);
    i2c_start();
    send_byte(8'h90, ack); check("t4_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h03, ack); check("t4_ptr_ack", 32'(ack), 32'd0);
    send_byte(8'hAA, ack); check("t4_d0_ack", 32'(ack), 32'd0);
    send_byte(8'h55, ack); check("t4_d1_ack", 32'(ack), 32'd0);
    i2c_stop();
    exp_ptr = 8'h03;
    check("t4_ptr", 32'(reg_ptr_o), 32'(exp_ptr));
    check("t4_wr_pending", 32'(exp_wr.size()), 32'd0);

    // 5: pointer write, repeated START, read
    i2c_start();
    send_byte(8'h90, ack); check("t5_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h07, ack); check("t5_ptr_ack", 32'(ack), 32'd0);
    exp_ptr = 8'h07;
    check("t5_ptr", 32'(reg_ptr_o), 32'(exp_ptr));
    push_word(exp_ptr);
    i2c_start();
    send_byte(8'h91, ack); check("t5_raddr_ack", 32'(ack), 32'd0);
    read_byte(1'b0);
    read_byte(1'b1);
    i2c_stop();
    exp_ptr = exp_ptr + 8'd1;
    check("t5_ptr_after", 32'(reg_ptr_o), 32'(exp_ptr));

    // 6: reset while driving a read data bit
    i2c_start();
    send_byte(8'h91, ack); check("t6_addr_ack", 32'(ack), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (sda_oe_o) seen = 1'b1;
    end
    check("t6_driving", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_oe", 32'(sda_oe_o), 32'd0);
    check("t6_rst_busy", 32'(busy_o), 32'd0);
    scl_m = 1'b1; sda_m = 1'b1;
    clks(H);
    @(negedge clk) rst_n = 1'b1;
    clks(4);
    exp_ptr = 8'h00;
    exp_rd.push_back(regs[exp_ptr][15:8]);
    i2c_start();
    send_byte(8'h91, ack); check("t6_re_ack", 32'(ack), 32'd0);
    check("t6_busy", 32'(busy_o), 32'd1);
    read_byte(1'b1);
    i2c_stop();
    check("t6_ptr", 32'(reg_ptr_o), 32'(exp_ptr));
    check("rd_pending", 32'(exp_rd.size()), 32'd0);

    clks(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
